apb_slave_mem: RTL



---
 rtl/apb_slv_pkg.sv | 17 +
 rtl/apb_slv_wait_ctr.sv | 38 +++
 rtl/apb_slave_mem.sv | 119 +++++++++++
 3 files changed

// File: rtl/apb_slv_pkg.sv
// Shared state type and width constants for the APB memory completer
// and the bus-side agent that drives it.
package apb_slv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    // Wide enough for the largest legal wait-state count (15).
    localparam int WAIT_CNT_W = 4;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// Loadable down-counter with a zero flag; it paces the access phase and
// decides the cycle in which PREADY rises.
module apb_slv_wait_ctr
    import apb_slv_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [WAIT_CNT_W-1:0] load_val_i,
    input  logic                  dec_i,
    output logic                  zero_o
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // NOTE: next-state logic assigns its default first so that no path leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a MEM_DEPTH x DATA_WIDTH register memory and WAIT_CYCLES wait states.
// Define APB_SLV_ERR_EN to answer out-of-range completions with PSLVERR.
module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int ADDR_WIDTH  = APB_ADDR_W,
    parameter int DATA_WIDTH  = APB_DATA_W,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    apb_state_e            state_q;
    apb_state_e            state_d;
    apb_state_e            phase;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  setup_now;
    logic                  cnt_zero;
    logic                  in_access;
    logic                  in_range;
    logic                  wr_commit;
    logic                  rd_done;
    logic [IDX_W-1:0]      idx;

    // The setup phase is the idle cycle in which the bus presents PSEL without
    // PENABLE; resolving it here lets a zero-wait transfer finish in two cycles.
    always_comb begin
        phase = state_q;
        if ((state_q == IDLE) && PSEL && !PENABLE) begin
            phase = SETUP;
        end
    end

    assign setup_now = (phase == SETUP);
    assign in_access = (state_q == ACCESS);

    always_comb begin
        state_d = state_q;
        unique case (phase)
            IDLE:    state_d = IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (!PSEL || cnt_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            pwrite_q <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (setup_now) begin
                addr_q   <= PADDR;
                pwrite_q <= PWRITE;
                wdata_q  <= PWDATA;
            end
        end
    end

    apb_slv_wait_ctr u_wait_ctr (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .load_i     (setup_now),
        .load_val_i (WAIT_CNT_W'(WAIT_CYCLES)),
        .dec_i      (in_access),
        .zero_o     (cnt_zero)
    );

    assign PREADY   = in_access && cnt_zero;
    assign in_range = (32'(addr_q) < MEM_DEPTH);
    assign idx      = addr_q[IDX_W-1:0];

    // A deselect in the completion cycle counts as an abort, so it cannot commit.
    assign wr_commit = PREADY && PSEL && pwrite_q && in_range;
    assign rd_done   = PREADY && !pwrite_q && in_range;

    // NOTE: the memory is reset word by word because reads after reset must return zero.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_commit) begin
            mem_q[idx] <= wdata_q;
        end
    end

    assign PRDATA = rd_done ? mem_q[idx] : '0;

`ifdef APB_SLV_ERR_EN
    assign PSLVERR = PREADY && !in_range;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule
